seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the board's 8-digit common-anode 7-segment display. It holds one register per digit, written by the processor's MMIO bus. It cycles through the digits with a blanking gap between them. It drives the active-low anode and segment lines through an instance of the hex-to-segment decoder.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..8)
DIGIT_CYC, 100000, clk cycles each digit is lit (>=2)
BLANK_CYC, 2000, clk cycles all anodes off between digits (>=1); anti-ghosting gap
CNT_W, 17, width of the phase counter; must hold max(DIGIT_CYC, BLANK_CYC)-1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = scanning, 0 = display dark
clr  in  1  single-cycle pulse; sets every digit to blank
wr_en  in  1  single-cycle write strobe from MMIO decoder
wr_addr  in  3  digit index, 0 = rightmost
wr_data  in  8  [3:0] hex value, [4] decimal point on, [5] blank digit, [7:6] ignored
wr_ack  out  1  pulses one cycle after every wr_en
an  out  8  anode selects, active-low; bits >= NUM_DIGITS are always 1
seg  out  8  segments, active-low; [7] = decimal point, [6:0] = g..a

Behaviour:
- Reset (async on rst_n low):
  - an = 8'hFF, seg = 8'hFF, wr_ack = 0.
  - All digit registers = blank (value 0, dp 0, blank 1).
  - Digit index = 0, state = BLANK, phase counter = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Digit register: 6 bits {blank, dp, hex[3:0]}. The write stores wr_data[5:0] at the clock edge where wr_en = 1.
- wr_ack = 1 on the cycle after wr_en, including writes with wr_addr >= NUM_DIGITS. Those writes change no state.
- clr and wr_en in the same cycle: all digits are blanked, then the written digit takes wr_data (write wins for its own digit).
- FSM has two states:
  - BLANK:
    - an = all 1, seg = 8'hFF.
    - Counter counts 0..BLANK_CYC-1.
    - On terminal count: go to SHOW, counter cleared, index advanced (index+1, wraps NUM_DIGITS-1 -> 0).
    - At that same edge, the shadow register latches regs[new index].
    - Exception: the first BLANK after reset or after enable rises does not advance, so digit 0 shows first.
  - SHOW:
    - an = ~(1 << index), seg = decoder(shadow.hex) with seg[7] = ~shadow.dp.
    - If shadow.blank = 1, an stays lit but seg = 8'hFF.
    - Counter counts 0..DIGIT_CYC-1; on terminal count go to BLANK, counter cleared.
- Shadow latch: a write to the digit currently lit does not change seg until that digit's next SHOW period. This prevents mid-period glitches.
- Latency: a write becomes visible at the next BLANK->SHOW entry for that digit. The worst case is NUM_DIGITS*(DIGIT_CYC+BLANK_CYC) cycles.
- enable = 0:
  - Next edge forces state BLANK, counter 0, an = 8'hFF, seg = 8'hFF.
  - Index is reset to 0.
  - Register writes and wr_ack continue to work.
- enable rising: scanning restarts with one full BLANK period, then digit 0.
- Decoder instance: default codes (value >= 16) cannot occur, because hex is 4 bits zero-extended to 8.
- Counter and index never exceed their range. Index compares use NUM_DIGITS, not 8.

Decomposition:
- Shared package seg_pkg:
  - SEG_OFF = 8'hFF, AN_OFF = 8'hFF.
  - Digit-register field offsets: HEX_LSB = 0, DP_BIT = 4, BLANK_BIT = 5.
  - FSM state encoding: ST_BLANK = 0, ST_SHOW = 1.
- Sub-module: the existing hex-to-segment decoder, instantiated once on the shadow value.
- The digit register file stays inline; it is too small to split.

Test Plan (sim params NUM_DIGITS=4, DIGIT_CYC=4, BLANK_CYC=1):
1. Reset, enable=1 with no writes -> an cycles through 1110, 1101, 1011, 0111, each lit 4 cycles with 1 cycle of an=1111 between; seg=FF throughout (all blank).
2. Write addr0=0x05, addr1=0x1A (A with dp), addr2=0x20 (blank). Then:
   - digit0: seg=0x92.
   - digit1: seg=0x08 (dp on, A).
   - digit2: an lit, seg=FF.
   - digit3: seg=FF.
   - wr_ack pulses once per write, one cycle after wr_en.
3. While digit1 is lit showing 0x08, write addr1=0x03 -> seg stays 0x08 until BLANK; the next digit1 period shows 0xB0.
4. wr_en with wr_addr=6 -> wr_ack=1 next cycle; no digit changes. Same cycle clr=1 and write addr0=0x0F -> digits 1..3 blank; digit0 shows 0x8E.
5. Drop enable mid-SHOW of digit2 -> next cycle an=FF, seg=FF. Re-raise enable -> 1 BLANK cycle, then digit0 lit. Registers are preserved.
6. Assert rst_n=0 asynchronously mid-SHOW -> an=FF, seg=FF, wr_ack=0 with no clock edge. After release, all digits read back blank.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and types for the 7-segment scan controller.
// Field offsets, idle output codes and FSM state encoding.
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    localparam int HEX_LSB   = 0;
    localparam int DP_BIT    = 4;
    localparam int BLANK_BIT = 5;

    localparam logic [5:0] DIGIT_BLANK = 6'b10_0000;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

endpackage

// File: rtl/seg_scan_ctrl_hex.sv
// Hex-to-segment decoder, active-low, segs[6:0] = g..a.
// Codes 16 and above decode to all segments off.
module seg_scan_ctrl_hex (
    input  logic [7:0] code,
    output logic [6:0] segs
);

    // Pure lookup from value to lit segment pattern
    always_comb begin
        segs = 7'h7F;
        case (code)
            8'h00: segs = 7'h40;
            8'h01: segs = 7'h79;
            8'h02: segs = 7'h24;
            8'h03: segs = 7'h30;
            8'h04: segs = 7'h19;
            8'h05: segs = 7'h12;
            8'h06: segs = 7'h02;
            8'h07: segs = 7'h78;
            8'h08: segs = 7'h00;
            8'h09: segs = 7'h10;
            8'h0A: segs = 7'h08;
            8'h0B: segs = 7'h03;
            8'h0C: segs = 7'h46;
            8'h0D: segs = 7'h21;
            8'h0E: segs = 7'h06;
            8'h0F: segs = 7'h0E;
            default: segs = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode display.
// Digit registers are MMIO-written; each digit is shown from a shadow copy.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DIGIT_CYC  = 100000,
    parameter int BLANK_CYC  = 2000,
    parameter int CNT_W      = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       clr,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic [7:0] an,
    output logic [7:0] seg
);

    localparam logic [3:0]       NUM_D     = 4'(NUM_DIGITS);
    localparam logic [2:0]       LAST_IDX  = 3'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_END  = CNT_W'(DIGIT_CYC - 1);

    logic [5:0]       regs [8];
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic [5:0]       shadow, shadow_n;
    logic             first, first_n;
    logic [6:0]       dec_segs;
    logic [7:0]       an_n, seg_n;
    logic             unused_ok;

    assign unused_ok = ^wr_data[7:6];

    // Digit register file: clear blanks all, a valid write then wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= DIGIT_BLANK;
        end else begin
            if (clr) begin
                for (int i = 0; i < 8; i++) regs[i] <= DIGIT_BLANK;
            end
            if (wr_en && ({1'b0, wr_addr} < NUM_D)) begin
                regs[wr_addr] <= wr_data[5:0];
            end
        end
    end

    // Write acknowledge, one cycle after every strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_ack <= 1'b0;
        else        wr_ack <= wr_en;
    end

    // Scan FSM state, counter, digit index and shadow copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_BLANK;
            cnt    <= '0;
            idx    <= '0;
            shadow <= DIGIT_BLANK;
            first  <= 1'b1;
            an     <= AN_OFF;
            seg    <= SEG_OFF;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            shadow <= shadow_n;
            first  <= first_n;
            an     <= an_n;
            seg    <= seg_n;
        end
    end

    // Next-state logic; outputs derive from next state so they stay aligned
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        shadow_n = shadow;
        first_n  = first;
        if (!enable) begin
            state_n = ST_BLANK;
            cnt_n   = '0;
            idx_n   = '0;
            first_n = 1'b1;
        end else begin
            case (state)
                ST_BLANK: begin
                    if (cnt == BLANK_END) begin
                        state_n = ST_SHOW;
                        cnt_n   = '0;
                        first_n = 1'b0;
                        if (!first) begin
                            idx_n = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
                        end
                        shadow_n = regs[idx_n];
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt == SHOW_END) begin
                        state_n = ST_BLANK;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: state_n = ST_BLANK;
            endcase
        end
    end

    seg_scan_ctrl_hex u_hex (
        .code ({4'b0000, shadow_n[HEX_LSB +: 4]}),
        .segs (dec_segs)
    );

    // Anode and segment values for the upcoming cycle
    always_comb begin
        an_n  = AN_OFF;
        seg_n = SEG_OFF;
        if (state_n == ST_SHOW) begin
            an_n = ~(8'd1 << idx_n);
            if (!shadow_n[BLANK_BIT]) begin
                seg_n = {~shadow_n[DP_BIT], dec_segs};
            end
        end
    end

endmodule
